// File: rtl/tetris_pkg.sv
// Shared types and constants for the tetris command path.
// Holds the command encoding, pending-flag layout, shape count and LFSR constants.
// Also provides small helpers for counter sizing and LFSR stepping.
package tetris_pkg;

  localparam int unsigned NUM_SHAPES = 5;

  // Commands in the order field prioritises them (down first).
  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_DOWN,
    CMD_LEFT,
    CMD_RIGHT,
    CMD_ROTATE
  } cmd_e;

  // One bit per command; used for pending flags, grants and output pulses.
  typedef struct packed {
    logic down;
    logic left;
    logic right;
    logic rotate;
  } pend_t;

  // Galois LFSR for x^16+x^14+x^13+x^11+1, right-shifting form.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Purpose: synchronise and debounce one raw button; emit press and auto-repeat events.
// Latency: event register high DEBOUNCE_CYCLES+2 cycles after the raw edge is first sampled.
// Backpressure: none; events are single-cycle and the consumer must latch them.
module btn_debounce
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 8000,
  parameter int unsigned REPEAT_RATE     = 2000,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_evt
);

  localparam int unsigned DBW = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned RPW = cnt_width((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPW-1:0] DELAY_LAST = RPW'(REPEAT_DELAY - 1);
  localparam logic [RPW-1:0] RATE_LAST  = RPW'(REPEAT_RATE - 1);

  logic           r_sync1;
  logic           r_sync2;
  logic           r_level;
  logic           r_evt;
  logic           r_rep_phase;
  logic [DBW-1:0] r_db_cnt;
  logic [RPW-1:0] r_hold;

  logic           w_differ;
  logic           w_flip;
  logic           w_level_nxt;
  logic           w_holding;
  logic           w_rep_fire;
  logic [RPW-1:0] w_rep_lim;

  // Decide whether the level flips this cycle and whether a repeat is due.
  // A repeat is suppressed on the cycle the level is about to fall.
  always_comb begin
    w_differ    = (r_sync2 != r_level);
    w_flip      = w_differ && (r_db_cnt == DB_LAST);
    w_level_nxt = w_flip ? r_sync2 : r_level;
    w_holding   = REPEAT_EN && r_level && w_level_nxt;
    w_rep_lim   = r_rep_phase ? RATE_LAST : DELAY_LAST;
    w_rep_fire  = w_holding && (r_hold == w_rep_lim);
  end

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count consecutive differing samples; any agreeing sample clears.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_db_cnt <= '0;
      r_level  <= 1'b0;
    end else if (!w_differ || w_flip) begin
      r_db_cnt <= '0;
      r_level  <= w_level_nxt;
    end else begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // Hold counter: first interval is REPEAT_DELAY, then REPEAT_RATE thereafter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (!w_holding) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_rep_fire) begin
      r_hold      <= '0;
      r_rep_phase <= 1'b1;
    end else begin
      r_hold <= r_hold + 1'b1;
    end
  end

  // Event register: debounced rising edge or a due repeat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_evt <= 1'b0;
    end else begin
      r_evt <= (w_flip && r_sync2) || w_rep_fire;
    end
  end

  assign o_evt = r_evt;

endmodule

// File: rtl/tetris_input_ctrl.sv
// Purpose: turn buttons and a gravity timer into one-hot command pulses and a shape index for field.
// Latency: button press to pulse DEBOUNCE_CYCLES+3 cycles; gravity pulse every GRAVITY_CYCLES cycles.
// Backpressure: none from field; commands wait as pending flags and pulses are spaced by HOLDOFF idle cycles.
module tetris_input_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned REPEAT_DELAY    = 8000,
  parameter int unsigned REPEAT_RATE     = 2000,
  parameter int unsigned GRAVITY_CYCLES  = 50000,
  parameter int unsigned HOLDOFF         = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnDown,
  input  logic       btnRotate,
  input  logic       gameOver,
  output logic       leftTrue,
  output logic       rightTrue,
  output logic       downTrue,
  output logic       rotateTrue,
  output logic [2:0] blockType
);

  localparam int unsigned GW = cnt_width(GRAVITY_CYCLES);
  localparam int unsigned HW = cnt_width(HOLDOFF + 1);
  localparam logic [GW-1:0] GRAV_LAST  = GW'(GRAVITY_CYCLES - 1);
  localparam logic [HW-1:0] HOLDOFF_LD = HW'(HOLDOFF);
  localparam logic [2:0]    SHAPE_LIM  = 3'(NUM_SHAPES);

  logic          w_evt_l;
  logic          w_evt_r;
  logic          w_evt_d;
  logic          w_evt_rot;
  logic          w_grav_evt;
  pend_t         w_req;
  pend_t         w_gnt_mask;
  cmd_e          w_grant;

  pend_t         r_pend;
  pend_t         r_pulse;
  logic [GW-1:0] r_grav;
  logic [HW-1:0] r_holdoff;
  logic [15:0]   r_lfsr;
  logic [2:0]    r_shape;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_db_left (
    .clock(clock), .reset(reset), .i_btn(btnLeft), .o_evt(w_evt_l)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_db_right (
    .clock(clock), .reset(reset), .i_btn(btnRight), .o_evt(w_evt_r)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b1)
  ) u_db_down (
    .clock(clock), .reset(reset), .i_btn(btnDown), .o_evt(w_evt_d)
  );

  // Rotate is a one-shot action, so it never auto-repeats.
  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_RATE(REPEAT_RATE), .REPEAT_EN(1'b0)
  ) u_db_rotate (
    .clock(clock), .reset(reset), .i_btn(btnRotate), .o_evt(w_evt_rot)
  );

  assign w_grav_evt = !gameOver && (r_grav == GRAV_LAST);

  // Merge fresh events with pending flags and pick one command by priority.
  // Fresh events are visible to the arbiter in the same cycle they arrive.
  always_comb begin
    w_req.down   = r_pend.down   | w_evt_d | w_grav_evt;
    w_req.left   = r_pend.left   | w_evt_l;
    w_req.right  = r_pend.right  | w_evt_r;
    w_req.rotate = r_pend.rotate | w_evt_rot;
    w_grant      = CMD_NONE;
    w_gnt_mask   = '0;
    if (!gameOver && (r_holdoff == '0)) begin
      if (w_req.down) begin
        w_grant         = CMD_DOWN;
        w_gnt_mask.down = 1'b1;
      end else if (w_req.left) begin
        w_grant         = CMD_LEFT;
        w_gnt_mask.left = 1'b1;
      end else if (w_req.right) begin
        w_grant          = CMD_RIGHT;
        w_gnt_mask.right = 1'b1;
      end else if (w_req.rotate) begin
        w_grant           = CMD_ROTATE;
        w_gnt_mask.rotate = 1'b1;
      end
    end
  end

  // Pending flags: keep everything not granted; gameOver flushes them all.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pend <= '0;
    end else if (gameOver) begin
      r_pend <= '0;
    end else begin
      r_pend <= pend_t'(w_req & ~w_gnt_mask);
    end
  end

  // Registered one-hot command pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_gnt_mask;
    end
  end

  // Gravity timer: restarts on wrap or whenever any down pulse goes out.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grav <= '0;
    end else if (gameOver || (w_grant == CMD_DOWN) || (r_grav == GRAV_LAST)) begin
      r_grav <= '0;
    end else begin
      r_grav <= r_grav + 1'b1;
    end
  end

  // Holdoff: enforce idle cycles after each pulse so a spawn cycle cannot eat a command.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_holdoff <= '0;
    end else if (gameOver) begin
      r_holdoff <= '0;
    end else if (w_grant != CMD_NONE) begin
      r_holdoff <= HOLDOFF_LD;
    end else if (r_holdoff != '0) begin
      r_holdoff <= r_holdoff - 1'b1;
    end
  end

  // Free-running LFSR; keeps stepping during gameOver so shapes stay varied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  // Shape index follows the LFSR low bits only when they name a valid shape.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shape <= 3'd0;
    end else if (r_lfsr[2:0] < SHAPE_LIM) begin
      r_shape <= r_lfsr[2:0];
    end
  end

  assign downTrue   = r_pulse.down;
  assign leftTrue   = r_pulse.left;
  assign rightTrue  = r_pulse.right;
  assign rotateTrue = r_pulse.rotate;
  assign blockType  = r_shape;

endmodule

// File: tb/tb_tetris_input_ctrl.sv
// Directed bench for tetris_input_ctrl with small timing parameters.
// Pulses are logged by cycle number at the falling edge and compared to hand-derived offsets.
module tb_tetris_input_ctrl;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;
  localparam int GC = 50;
  localparam int HO = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       btnLeft, btnRight, btnDown, btnRotate, gameOver;
  logic       leftTrue, rightTrue, downTrue, rotateTrue;
  logic [2:0] blockType;

  tetris_input_ctrl #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .GRAVITY_CYCLES(GC), .HOLDOFF(HO)
  ) dut (
    .clock(clock), .reset(reset),
    .btnLeft(btnLeft), .btnRight(btnRight), .btnDown(btnDown), .btnRotate(btnRotate),
    .gameOver(gameOver),
    .leftTrue(leftTrue), .rightTrue(rightTrue), .downTrue(downTrue), .rotateTrue(rotateTrue),
    .blockType(blockType)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int q_l[$];
  int q_r[$];
  int q_d[$];
  int q_rot[$];
  int n_multi = 0;
  int n_gap = 0;
  int last_p = -100;

  always @(posedge clock) cyc <= cyc + 1;

  // Pulse log plus one-hot and spacing watch, sampled mid-cycle.
  always @(negedge clock) begin
    if (leftTrue)   q_l.push_back(cyc);
    if (rightTrue)  q_r.push_back(cyc);
    if (downTrue)   q_d.push_back(cyc);
    if (rotateTrue) q_rot.push_back(cyc);
    if ($countones({leftTrue, rightTrue, downTrue, rotateTrue}) > 1) n_multi++;
    if (leftTrue || rightTrue || downTrue || rotateTrue) begin
      if (cyc - last_p <= HO) n_gap++;
      last_p = cyc;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1000;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clr_q();
    q_l.delete();
    q_r.delete();
    q_d.delete();
    q_rot.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    clr_q();
  endtask

  int t, t1;
  int changes;
  int mx;
  logic [2:0] prev_bt;
  logic [7:0] seen;
  int rep_off[5] = '{7, 27, 32, 37, 42};

  initial begin
    reset = 1'b1;
    btnLeft = 1'b0; btnRight = 1'b0; btnDown = 1'b0; btnRotate = 1'b0;
    gameOver = 1'b0;
    tick(3);
    chk("reset_pulses", int'({leftTrue, rightTrue, downTrue, rotateTrue}), 0);
    chk("reset_shape", int'(blockType), 0);

    // Glitch of DB-1 samples is rejected; stable press gives one pulse 7 cycles later.
    do_reset();
    btnLeft = 1'b1; tick(3);
    btnLeft = 1'b0; tick(3);
    btnLeft = 1'b1; t1 = cyc; tick(10);
    btnLeft = 1'b0; tick(10);
    chk("glitch_count", q_l.size(), 1);
    chk("glitch_latency", qat(q_l, 0) - t1, 7);
    chk("glitch_others", q_r.size() + q_d.size() + q_rot.size(), 0);

    // Auto-repeat on right: press plus hold cycles 20, 25, 30, 35.
    do_reset();
    btnRight = 1'b1; t = cyc; tick(40);
    btnRight = 1'b0; tick(8);
    chk("repeat_count", q_r.size(), 5);
    for (int i = 0; i < 5; i++) chk($sformatf("repeat_at_%0d", i), qat(q_r, i) - t, rep_off[i]);

    // Rotate never repeats.
    do_reset();
    btnRotate = 1'b1; t = cyc; tick(40);
    btnRotate = 1'b0; tick(8);
    chk("rotate_count", q_rot.size(), 1);
    chk("rotate_latency", qat(q_rot, 0) - t, 7);

    // Gravity alone: a down pulse every 50 cycles.
    do_reset();
    t = cyc; tick(160);
    chk("grav_count", q_d.size(), 3);
    chk("grav_first", qat(q_d, 0) - t, 50);
    chk("grav_second", qat(q_d, 1) - t, 100);
    chk("grav_third", qat(q_d, 2) - t, 150);

    // Button down at cycle 30 restarts gravity.
    do_reset();
    tick(30);
    btnDown = 1'b1; t = cyc; tick(10);
    btnDown = 1'b0; tick(57);
    chk("down_btn_count", q_d.size(), 2);
    chk("down_btn_latency", qat(q_d, 0) - t, 7);
    chk("down_grav_restart", qat(q_d, 1) - t, 57);

    // Simultaneous left/right/rotate come out in priority order, 3 cycles apart.
    do_reset();
    btnLeft = 1'b1; btnRight = 1'b1; btnRotate = 1'b1; t = cyc; tick(20);
    btnLeft = 1'b0; btnRight = 1'b0; btnRotate = 1'b0; tick(8);
    chk("prio_left", qat(q_l, 0) - t, 7);
    chk("prio_right", qat(q_r, 0) - t, 10);
    chk("prio_rotate", qat(q_rot, 0) - t, 13);
    chk("prio_total", q_l.size() + q_r.size() + q_rot.size() + q_d.size(), 3);

    // gameOver with left pending: silence, flags flushed, gravity restarts on fall.
    do_reset();
    btnDown = 1'b1; btnLeft = 1'b1; t = cyc; tick(7);
    chk("go_down_first", int'(downTrue), 1);
    gameOver = 1'b1; btnDown = 1'b0; btnLeft = 1'b0;
    changes = 0;
    prev_bt = blockType;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (blockType != prev_bt) changes++;
      prev_bt = blockType;
    end
    chk("go_quiet_left", q_l.size(), 0);
    chk("go_quiet_down", q_d.size(), 1);
    chk("go_quiet_rr", q_r.size() + q_rot.size(), 0);
    chk("go_shape_varies", (changes > 0) ? 1 : 0, 1);
    gameOver = 1'b0; t1 = cyc; tick(60);
    chk("go_grav_count", q_d.size(), 2);
    chk("go_grav_latency", qat(q_d, 1) - t1, 50);
    chk("go_no_stale_left", q_l.size(), 0);

    // Reset during holdoff while down is held; fresh debounce after release.
    do_reset();
    btnDown = 1'b1; tick(7);
    chk("rst_pre_pulse", int'(downTrue), 1);
    tick(1);
    reset = 1'b1;
    #1;
    chk("rst_mid_pulses", int'({leftTrue, rightTrue, downTrue, rotateTrue}), 0);
    chk("rst_mid_shape", int'(blockType), 0);
    tick(1);
    reset = 1'b0;
    clr_q();
    t = cyc; tick(12);
    chk("rst_after_count", q_d.size(), 1);
    chk("rst_after_latency", qat(q_d, 0) - t, 7);
    btnDown = 1'b0;

    // Shape range over 10000 cycles.
    do_reset();
    gameOver = 1'b1;
    mx = 0;
    seen = '0;
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      if (int'(blockType) > mx) mx = int'(blockType);
      seen[blockType] = 1'b1;
    end
    gameOver = 1'b0;
    chk("shape_max", (mx <= 4) ? 1 : 0, 1);
    chk("shape_seen", int'(seen), 'h1F);

    chk("onehot_pulses", n_multi, 0);
    chk("pulse_spacing", n_gap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
